// File: rtl/uart_transmitter_core.sv
// rtl/uart_transmitter_core.sv - UART transmitter: data register, framing shift register, baud/bit counters
// Frames are start(0), WORD_SIZE data bits LSB first, stop(1); txDone pulses the cycle after the stop bit ends.
module uart_transmitter_core #(
   parameter int BIT_COUNT_WIDTH = 4,
   parameter int WORD_SIZE       = 8,
   parameter int CLKS_PER_BIT    = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [WORD_SIZE-1:0] dataBus,
   input  logic                 ldXmtDataReg,
   input  logic                 byteReady,
   input  logic                 tByte,
   output logic                 serialOut,
   output logic                 txDone
);

   localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_COUNT_WIDTH-1:0] STOP_COUNT = BIT_COUNT_WIDTH'(WORD_SIZE + 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAITING = 2'd1,
      SENDING = 2'd2
   } state_e;

   state_e                     state_q, state_d;
   logic [WORD_SIZE-1:0]       xmt_data_q, xmt_data_d;
   logic [WORD_SIZE:0]         shift_q, shift_d;
   logic [BIT_COUNT_WIDTH-1:0] bit_count_q, bit_count_d;
   logic [BAUD_W-1:0]          baud_q, baud_d;
   logic                       tx_done_q, tx_done_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         xmt_data_q  <= '0;
         shift_q     <= '1;
         bit_count_q <= '0;
         baud_q      <= '0;
         tx_done_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         xmt_data_q  <= xmt_data_d;
         shift_q     <= shift_d;
         bit_count_q <= bit_count_d;
         baud_q      <= baud_d;
         tx_done_q   <= tx_done_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      shift_d     = shift_q;
      bit_count_d = bit_count_q;
      baud_d      = baud_q;
      tx_done_d   = 1'b0;
      // The data register is independent of the frame already captured in shift_q.
      xmt_data_d  = ldXmtDataReg ? dataBus : xmt_data_q;

      case (state_q)
         IDLE: begin
            if (byteReady) begin
               shift_d = {xmt_data_q, 1'b1};
               state_d = WAITING;
            end
         end
         WAITING: begin
            if (tByte) begin
               shift_d[0]  = 1'b0;
               bit_count_d = '0;
               baud_d      = '0;
               state_d     = SENDING;
            end
         end
         SENDING: begin
            if (baud_q == BAUD_LAST) begin
               baud_d  = '0;
               shift_d = {1'b1, shift_q[WORD_SIZE:1]};
               if (bit_count_q == STOP_COUNT) begin
                  bit_count_d = '0;
                  tx_done_d   = 1'b1;
                  state_d     = IDLE;
               end else begin
                  bit_count_d = bit_count_q + 1'b1;
               end
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign serialOut = shift_q[0];
   assign txDone    = tx_done_q;

endmodule

// File: tb/tb_uart_transmitter_core.sv
// tb/tb_uart_transmitter_core.sv - directed bench for uart_transmitter_core at CLKS_PER_BIT 1 and 4
// A frame-level model (10-bit frame indexed by elapsed cycles) is compared every cycle; literals pin it.
module tb_uart_transmitter_core;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] dataBus = 8'h00;
   logic       ldXmtDataReg = 1'b0;
   logic       byteReady = 1'b0;
   logic       tByte = 1'b0;
   logic       serial1, done1, serial4, done4;

   int passed = 0;
   int total = 0;
   bit started = 1'b0;

   always #5 clk = ~clk;

   uart_transmitter_core #(.BIT_COUNT_WIDTH(4), .WORD_SIZE(8), .CLKS_PER_BIT(1)) u_dut1 (
      .clk(clk), .reset(reset), .dataBus(dataBus), .ldXmtDataReg(ldXmtDataReg),
      .byteReady(byteReady), .tByte(tByte), .serialOut(serial1), .txDone(done1));

   uart_transmitter_core #(.BIT_COUNT_WIDTH(4), .WORD_SIZE(8), .CLKS_PER_BIT(4)) u_dut4 (
      .clk(clk), .reset(reset), .dataBus(dataBus), .ldXmtDataReg(ldXmtDataReg),
      .byteReady(byteReady), .tByte(tByte), .serialOut(serial4), .txDone(done4));

   // Model: phase 0 idle, 1 armed, 2 sending; m_cnt counts cycles since the start edge.
   int         m_phase [2] = '{0, 0};
   int         m_cnt   [2] = '{0, 0};
   logic [7:0] m_data  [2] = '{8'h00, 8'h00};
   logic [9:0] m_frame [2] = '{10'h3ff, 10'h3ff};
   logic       m_done  [2] = '{1'b0, 1'b0};

   function automatic int cpb(input int i);
      return (i == 0) ? 1 : 4;
   endfunction

   function automatic logic exp_line(input int i);
      if (m_phase[i] == 2) return m_frame[i][m_cnt[i] / cpb(i)];
      return 1'b1;
   endfunction

   task automatic model_step(input int i);
      if (reset) begin
         m_phase[i] = 0;
         m_cnt[i]   = 0;
         m_data[i]  = 8'h00;
         m_done[i]  = 1'b0;
      end else begin
         m_done[i] = 1'b0;
         case (m_phase[i])
            2: begin
               m_cnt[i]++;
               if (m_cnt[i] == 10 * cpb(i)) begin
                  m_phase[i] = 0;
                  m_done[i]  = 1'b1;
               end
            end
            1: if (tByte) begin
               m_phase[i] = 2;
               m_cnt[i]   = 0;
            end
            default: if (byteReady) begin
               m_frame[i] = {1'b1, m_data[i], 1'b0};
               m_phase[i] = 1;
            end
         endcase
         if (ldXmtDataReg) m_data[i] = dataBus;
      end
   endtask

   always @(posedge clk) begin
      model_step(0);
      model_step(1);
   end

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      else passed++;
   endtask

   always @(negedge clk) begin
      if (started) begin
         chk("model_serial_c1", int'(serial1), int'(exp_line(0)));
         chk("model_done_c1",   int'(done1),   int'(m_done[0]));
         chk("model_serial_c4", int'(serial4), int'(exp_line(1)));
         chk("model_done_c4",   int'(done4),   int'(m_done[1]));
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [7:0] d);
      dataBus = d;
      ldXmtDataReg = 1'b1;
      cyc();
      ldXmtDataReg = 1'b0;
   endtask

   task automatic arm_and_start();
      byteReady = 1'b1;
      cyc();
      byteReady = 1'b0;
      tByte = 1'b1;
      cyc();
      tByte = 1'b0;
   endtask

   task automatic wait_done(input int which, input int limit);
      for (int n = 0; n < limit; n++) begin
         cyc();
         if ((which == 0) ? done1 : done4) return;
      end
      total++;
      $display("FAIL wait_done_%0d: txDone not seen within %0d cycles", which, limit);
   endtask

   task automatic check_frame1(input string name, input logic [9:0] line);
      for (int k = 0; k < 10; k++) begin
         chk(name, int'(serial1), int'(line[k]));
         cyc();
      end
      chk({name, "_done"}, int'(done1), 1);
   endtask

   logic [9:0] line_a5 = 10'b1101001010;
   logic [9:0] line_3c = 10'b1001111000;
   logic [9:0] line_ff = 10'b1111111110;
   logic [9:0] line_96 = 10'b1100101100;
   logic [9:0] line_55 = 10'b1010101010;
   logic [9:0] line_c3 = 10'b1110000110;

   initial begin
      // Reset held three cycles with random controls.
      for (int k = 0; k < 3; k++) begin
         dataBus = 8'($urandom);
         ldXmtDataReg = 1'($urandom);
         byteReady = 1'($urandom);
         tByte = 1'($urandom);
         cyc();
         started = 1'b1;
         chk("reset_serial", int'(serial1 & serial4), 1);
         chk("reset_done", int'(done1 | done4), 0);
      end
      reset = 1'b0;
      dataBus = 8'h00;
      ldXmtDataReg = 1'b0;
      byteReady = 1'b0;
      tByte = 1'b0;
      cyc();
      chk("post_reset_serial", int'(serial1 & serial4), 1);
      chk("post_reset_done", int'(done1 | done4), 0);

      // 0xA5 at one clock per bit.
      load(8'hA5);
      arm_and_start();
      check_frame1("a5_line", line_a5);
      cyc();
      chk("a5_done_width", int'(done1), 0);
      chk("a5_idle_high", int'(serial1), 1);
      wait_done(1, 60);
      cyc();

      // 0x3C at four clocks per bit.
      load(8'h3C);
      arm_and_start();
      for (int k = 0; k < 40; k++) begin
         chk("3c_line_c4", int'(serial4), int'(line_3c[k / 4]));
         chk("3c_no_early_done", int'(done4), 0);
         cyc();
      end
      chk("3c_done_c4", int'(done4), 1);
      cyc();

      // Back-to-back: 0x00 then 0xFF, second frame armed in the txDone cycle.
      load(8'h00);
      arm_and_start();
      load(8'hFF);
      wait_done(0, 20);
      byteReady = 1'b1;
      cyc();
      byteReady = 1'b0;
      tByte = 1'b1;
      cyc();
      tByte = 1'b0;
      check_frame1("b2b_ff_line", line_ff);
      wait_done(1, 60);
      cyc();

      // Ignored controls: tByte in idle, new data and byteReady mid-frame.
      tByte = 1'b1;
      cyc();
      tByte = 1'b0;
      chk("idle_tbyte_ignored", int'(serial1), 1);
      load(8'h96);
      arm_and_start();
      for (int k = 0; k < 10; k++) begin
         chk("96_line", int'(serial1), int'(line_96[k]));
         if (k == 3) begin
            dataBus = 8'h55;
            ldXmtDataReg = 1'b1;
            byteReady = 1'b1;
         end
         cyc();
         ldXmtDataReg = 1'b0;
         byteReady = 1'b0;
      end
      chk("96_done", int'(done1), 1);
      wait_done(1, 60);
      cyc();
      arm_and_start();
      check_frame1("55_line", line_55);
      wait_done(1, 60);
      cyc();

      // Reset during data bit 4 aborts the frame silently.
      load(8'hC3);
      arm_and_start();
      repeat (4) cyc();
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      chk("abort_serial", int'(serial1 & serial4), 1);
      for (int k = 0; k < 12; k++) begin
         chk("abort_no_done", int'(done1 | done4), 0);
         cyc();
      end
      load(8'hC3);
      arm_and_start();
      check_frame1("c3_after_abort", line_c3);
      wait_done(1, 60);
      repeat (3) cyc();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/uart_transmitter_core.md
UART_TRANSMITTER_CORE -- requirements
Module: uart_transmitter

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter BIT_COUNT_WIDTH, default 4, giving the width of the bit counter; it must hold WORD_SIZE+1.
REQ-002 The block SHALL have parameter WORD_SIZE, default 8, giving the data bits per frame.
REQ-003 The block SHALL have parameter CLKS_PER_BIT, default 1, giving clock cycles per serial bit period (>=1).
Ports (name, direction, width, meaning):
REQ-004 The block SHALL have port clk, input, 1, the single clock; all logic SHALL be on its rising edge.
REQ-005 The block SHALL have port reset, input, 1, synchronous and active-high.
REQ-006 The block SHALL have port dataBus, input, WORD_SIZE, the byte to transmit.
REQ-007 The block SHALL have port ldXmtDataReg, input, 1, which loads dataBus into the data register.
REQ-008 The block SHALL have port byteReady, input, 1, which copies the data register into the shift register.
REQ-009 The block SHALL have port tByte, input, 1, which starts the frame.
REQ-010 The block SHALL have port serialOut, output, 1, the serial line: LSB of the shift register, idle high.
REQ-011 The block SHALL have port txDone, output, 1, a registered one-cycle pulse at frame end.

Function
REQ-012 The FSM SHALL have the states IDLE, WAITING and SENDING; serialOut SHALL always equal shiftReg[0] (shift register is WORD_SIZE+1 bits).
REQ-013 When ldXmtDataReg=1 in any state, xmtDataReg SHALL take dataBus at the next edge; a frame already in the shift register SHALL be unaffected.
REQ-014 In IDLE with byteReady=1, shiftReg SHALL take {xmtDataReg, 1'b1} and the state SHALL go to WAITING.
REQ-015 If ldXmtDataReg and byteReady are high in the same IDLE cycle, shiftReg SHALL take the old xmtDataReg value (register semantics).
REQ-016 In WAITING with tByte=1, shiftReg[0] SHALL be cleared (start bit), bitCount and the baud counter SHALL be zeroed, and the state SHALL go to SENDING; otherwise the block SHALL stay in WAITING.
REQ-017 In SENDING, the baud counter SHALL count 0..CLKS_PER_BIT-1; at terminal count a bit period completes.
REQ-018 At each completed bit period, shiftReg SHALL shift right with a 1 filled at the MSB, and bitCount SHALL increment.
REQ-019 The line sequence SHALL be: start 0, d0..d(WORD_SIZE-1) LSB first, stop 1, each lasting CLKS_PER_BIT cycles.
REQ-020 When the period completes with bitCount==WORD_SIZE+1 (the stop bit), the state SHALL go to IDLE, bitCount SHALL clear, and txDone SHALL be high for exactly the next cycle.
REQ-021 With tByte sampled at edge E0, txDone SHALL be high during [E0+10*CLKS_PER_BIT, +1 cycle) for WORD_SIZE=8.
REQ-022 byteReady outside IDLE and tByte outside WAITING SHALL be ignored.
REQ-023 A new frame SHALL be able to start the cycle after txDone: byteReady is accepted in the txDone cycle.
REQ-024 serialOut SHALL be 1 in IDLE and WAITING.

Reset
REQ-025 Reset=1 at a clock edge SHALL force: state IDLE, shiftReg all ones (serialOut=1), xmtDataReg=0, bitCount=0, baud counter=0, txDone=0.
REQ-026 Reset SHALL take priority over all inputs, including mid-frame, where the frame is aborted with no txDone pulse.

Verification
REQ-027 Reset: hold reset 3 cycles with random inputs -> serialOut=1 and txDone=0 throughout and after.
REQ-028 CLKS_PER_BIT=1, load 0xA5, byteReady, tByte -> serialOut 0,1,0,1,0,0,1,0,1,1 on successive cycles; txDone one-cycle pulse 10 cycles after tByte edge; serialOut=1 after.
REQ-029 CLKS_PER_BIT=4, send 0x3C -> each bit 4 cycles wide; txDone 40 cycles after tByte edge.
REQ-030 Back-to-back: frames 0x00 then 0xFF, second byteReady in the txDone cycle -> no gap beyond WAITING; both frames bit-exact.
REQ-031 Ignored controls: tByte in IDLE, byteReady and ldXmtDataReg during SENDING (new 0x55) -> current frame unchanged; the next frame sends 0x55.
REQ-032 Reset at bit 4 of a frame -> serialOut=1 the next cycle, no txDone, and the next full frame is correct.
